// File: rtl/rv32i_types.sv
// Shared types and constants for the burst memory responder.
//   BURST_BEATS  : beats per cacheline burst
//   BEAT_W       : width of one beat / storage word
//   bmem_state_e : responder FSM states
//   bmem_op_e    : latched request kind
package rv32i_types;

    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned BEAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } bmem_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } bmem_op_e;

endpackage

// File: rtl/burst_mem_responder_if.sv
// Cacheline burst bus between an initiator (master) and the responder (slave).
//   bmem_address : cacheline address from the initiator
//   bmem_read    : read request, held until the last beat
//   bmem_write   : write request, held until the last beat
//   bmem_wdata   : write beat, advanced after each resp cycle
//   bmem_rdata   : read beat, valid while bmem_resp=1
//   bmem_resp    : beat strobe from the responder
interface burst_mem_responder_if;
    import rv32i_types::*;

    logic [31:0]       bmem_address;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_resp;

    modport master (
        output bmem_address, bmem_read, bmem_write, bmem_wdata,
        input  bmem_rdata, bmem_resp
    );

    modport slave (
        input  bmem_address, bmem_read, bmem_write, bmem_wdata,
        output bmem_rdata, bmem_resp
    );
endinterface

// File: rtl/burst_mem_array.sv
// Beat storage: one port, synchronous write, combinational read.
// Powers up as all zeros; has no reset so contents survive rst.
//   i_clk   : clock
//   i_we    : write enable, word written at the rising edge
//   i_addr  : word address (line index, beat)
//   i_wdata : write word
//   o_rdata : word at i_addr
module burst_mem_array
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BEAT_W-1:0] i_wdata,
    output logic [BEAT_W-1:0] o_rdata
);

    logic [BEAT_W-1:0] r_mem [2**ADDR_W] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/burst_mem_responder.sv
// Cacheline burst memory responder. Accepts a read or write request in IDLE,
// waits LATENCY-1 cycles, streams four 64-bit beats, then spends one DONE
// cycle before returning to IDLE.
//   clk       : sole clock
//   rst       : synchronous active-high reset (storage is not cleared)
//   bmem      : burst bus, slave side
//   proto_err : sticky flag for both-ops-high or a request dropped mid-burst
module burst_mem_responder
    import rv32i_types::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned LINE_IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    burst_mem_responder_if.slave  bmem,
    output logic                  proto_err
);

    // WAIT runs while the down-counter walks from WAIT_INIT to 0.
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit         DIRECT    = (LATENCY == 1);

    bmem_state_e           r_state;
    bmem_op_e              r_op;
    logic [LINE_IDX_W-1:0] r_line;
    logic [1:0]            r_beat;
    logic [3:0]            r_wait;
    logic                  r_proto_err;

    logic                  w_req;
    logic                  w_req_line;
    logic                  w_resp;
    logic                  w_we;
    logic [BEAT_W-1:0]     w_mem_rdata;
    logic                  w_unused_addr_bits;

    assign w_req      = bmem.bmem_read | bmem.bmem_write;
    // Only the request line matching the latched op keeps the burst alive.
    assign w_req_line = (r_op == OP_WRITE) ? bmem.bmem_write : bmem.bmem_read;
    assign w_resp     = (r_state == BURST);
    // A write beat whose request line has dropped is not stored.
    assign w_we       = w_resp && (r_op == OP_WRITE) && bmem.bmem_write;

    assign w_unused_addr_bits = ^{bmem.bmem_address[31:5+LINE_IDX_W], bmem.bmem_address[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_READ;
            r_line      <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op   <= bmem.bmem_write ? OP_WRITE : OP_READ;
                        r_line <= bmem.bmem_address[5 +: LINE_IDX_W];
                        r_beat <= '0;
                        r_wait <= WAIT_INIT;
                        if (bmem.bmem_read && bmem.bmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                        r_state <= DIRECT ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req_line) begin
                        r_state     <= IDLE;
                        r_wait      <= '0;
                        r_proto_err <= 1'b1;
                    end else if (r_wait == '0) begin
                        r_state <= BURST;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                BURST: begin
                    if (!w_req_line) begin
                        r_state     <= IDLE;
                        r_beat      <= '0;
                        r_proto_err <= 1'b1;
                    end else if (r_beat == 2'(BURST_BEATS - 1)) begin
                        r_state <= DONE;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    burst_mem_array #(
        .ADDR_W(LINE_IDX_W + 2)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  ({r_line, r_beat}),
        .i_wdata (bmem.bmem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bmem.bmem_resp  = w_resp;
    assign bmem.bmem_rdata = w_resp ? w_mem_rdata : '0;
    assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    localparam int unsigned LATENCY    = 4;
    localparam int unsigned LINE_IDX_W = 6;
    localparam int unsigned LINES      = 1 << LINE_IDX_W;
    localparam int unsigned WORDS      = LINES * 4;

    logic clk;
    logic rst;
    logic proto_err;

    burst_mem_responder_if bmem_if ();

    burst_mem_responder #(
        .LATENCY    (LATENCY),
        .LINE_IDX_W (LINE_IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bmem      (bmem_if),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    // Transaction-level reference: flat word array plus a sticky error bit.
    logic [63:0] model_mem [WORDS];
    bit          model_perr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one burst starting in an IDLE cycle. stop_beat<4 ends it early at
    // that beat: by dropping the request lines, or by asserting reset.
    task automatic run_burst(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3,
                             input int stop_beat, input bit stop_rst, input bit hold);
        logic [63:0] wd [4];
        int unsigned line;
        bit          is_wr;
        wd    = '{d0, d1, d2, d3};
        line  = (addr >> 5) % LINES;
        is_wr = wr;

        @(negedge clk);
        check("idle_resp", 64'(bmem_if.bmem_resp), 64'd0);
        bmem_if.bmem_address = addr;
        bmem_if.bmem_read    = rd;
        bmem_if.bmem_write   = wr;
        bmem_if.bmem_wdata   = wd[0];
        if (rd && wr) model_perr = 1'b1;

        for (int c = 1; c < LATENCY; c++) begin
            @(negedge clk);
            check("wait_resp", 64'(bmem_if.bmem_resp), 64'd0);
            check("wait_rdata", bmem_if.bmem_rdata, 64'd0);
            bmem_if.bmem_address = $urandom;
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("beat_resp", 64'(bmem_if.bmem_resp), 64'd1);
            if (!is_wr) check("beat_rdata", bmem_if.bmem_rdata, model_mem[line*4 + k]);
            if (k == stop_beat) begin
                bmem_if.bmem_read  = 1'b0;
                bmem_if.bmem_write = 1'b0;
                if (stop_rst) rst = 1'b1;
                @(negedge clk);
                check("stop_resp", 64'(bmem_if.bmem_resp), 64'd0);
                check("stop_rdata", bmem_if.bmem_rdata, 64'd0);
                if (stop_rst) model_perr = 1'b0;
                else          model_perr = 1'b1;
                check("stop_perr", 64'(proto_err), 64'(model_perr));
                rst = 1'b0;
                return;
            end
            bmem_if.bmem_wdata = wd[k];
            if (is_wr) model_mem[line*4 + k] = wd[k];
        end

        @(negedge clk);
        check("done_resp", 64'(bmem_if.bmem_resp), 64'd0);
        check("done_rdata", bmem_if.bmem_rdata, 64'd0);
        check("done_perr", 64'(proto_err), 64'(model_perr));
        if (!hold) begin
            bmem_if.bmem_read  = 1'b0;
            bmem_if.bmem_write = 1'b0;
        end
    endtask

    task automatic read_line(input logic [31:0] addr);
        run_burst(1'b1, 1'b0, addr, '0, '0, '0, '0, 4, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_perr = 1'b0;
        check("rst_perr", 64'(proto_err), 64'd0);
        check("rst_resp", 64'(bmem_if.bmem_resp), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] r0, r1, r2, r3;
        int unsigned sel;
        int unsigned stop;
        bit          rd, wr;

        n_checks   = 0;
        n_errors   = 0;
        model_perr = 1'b0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = '0;

        rst                  = 1'b1;
        bmem_if.bmem_address = '0;
        bmem_if.bmem_read    = 1'b0;
        bmem_if.bmem_write   = 1'b0;
        bmem_if.bmem_wdata   = '0;

        repeat (3) @(negedge clk);
        check("reset_resp", 64'(bmem_if.bmem_resp), 64'd0);
        check("reset_rdata", bmem_if.bmem_rdata, 64'd0);
        check("reset_perr", 64'(proto_err), 64'd0);
        rst = 1'b0;

        // Write then read back line 2.
        run_burst(1'b0, 1'b1, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 4, 1'b0, 1'b0);
        read_line(32'h40);

        // Aliasing: 0x800 wraps onto line 0; 0x5F hits line 2.
        run_burst(1'b0, 1'b1, 32'h800, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 4, 1'b0, 1'b0);
        read_line(32'h0);
        read_line(32'h5F);

        // Read held through DONE: second burst only after re-sampling in IDLE.
        run_burst(1'b1, 1'b0, 32'h40, '0, '0, '0, '0, 4, 1'b0, 1'b1);
        run_burst(1'b1, 1'b0, 32'h40, '0, '0, '0, '0, 4, 1'b0, 1'b0);

        // Both ops high is served as a write.
        run_burst(1'b1, 1'b1, 32'h80, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 4, 1'b0, 1'b0);
        read_line(32'h80);

        // Write abort after beat 1 keeps beats 0,1 and leaves 2,3 intact.
        reset_pulse();
        run_burst(1'b0, 1'b1, 32'hC0, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 4, 1'b0, 1'b0);
        run_burst(1'b0, 1'b1, 32'hC0, 64'hC0, 64'hC1, 64'hC2, 64'hC3, 2, 1'b0, 1'b0);
        read_line(32'hC0);

        // Reset at beat 2 of a read; contents preserved.
        run_burst(1'b1, 1'b0, 32'h40, '0, '0, '0, '0, 2, 1'b1, 1'b0);
        read_line(32'h40);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel == 0) || (sel > 4);
            wr  = (sel <= 4);
            r0  = {$urandom, $urandom};
            r1  = {$urandom, $urandom};
            r2  = {$urandom, $urandom};
            r3  = {$urandom, $urandom};
            stop = $urandom_range(0, 7);
            if (stop == 0)
                run_burst(rd, wr, $urandom, r0, r1, r2, r3, $urandom_range(0, 3), 1'b0, 1'b0);
            else if (stop == 1)
                run_burst(rd, wr, $urandom, r0, r1, r2, r3, $urandom_range(0, 3), 1'b1, 1'b0);
            else
                run_burst(rd, wr, $urandom, r0, r1, r2, r3, 4, 1'b0, 1'b0);
        end

        // Final sweep of a few lines against the model.
        for (int l = 0; l < 8; l++) read_line(32'(l * 32));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
